// File: rtl/sd_spi_responder_if.sv
// ---------------------------------------------------------------------------
// sd_spi_responder_if
//   Bundles the SPI-mode SD command link plus the responder's status outputs.
//
//   Signals
//     sd_sclk    host -> card  SPI clock (asynchronous to the system clock)
//     sd_cs_n    host -> card  chip select, active low
//     sd_mosi    host -> card  command data
//     sd_miso    card -> host  response data, idles high
//     cmd_valid  card status   one-clock pulse per accepted frame
//     cmd_index  card status   index of the last accepted command
//     cmd_arg    card status   argument of the last accepted command
//     card_idle  card status   R1 in_idle_state bit
//     busy       card status   high from start bit through last R1 bit
//
//   Modports
//     master : the host / bench side
//     slave  : the responder side
// ---------------------------------------------------------------------------
interface sd_spi_responder_if;
  logic        sd_sclk;
  logic        sd_cs_n;
  logic        sd_mosi;
  logic        sd_miso;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        card_idle;
  logic        busy;

  modport master (
    output sd_sclk, sd_cs_n, sd_mosi,
    input  sd_miso, cmd_valid, cmd_index, cmd_arg, card_idle, busy
  );

  modport slave (
    input  sd_sclk, sd_cs_n, sd_mosi,
    output sd_miso, cmd_valid, cmd_index, cmd_arg, card_idle, busy
  );
endinterface

// File: rtl/sd_spi_responder.sv
// ---------------------------------------------------------------------------
// sd_spi_responder
//   Card-side end of an SPI-mode SD command link. Oversamples the host's
//   SCLK / CS_n / MOSI in the system clock domain, deframes 48-bit command
//   frames, runs a minimal init machine (CMD0 / CMD55 / ACMD41) and returns
//   one R1 byte per command after RESP_DELAY bytes of 0xFF.
//
//   Parameters
//     RESP_DELAY  NCR gap in whole 0xFF bytes (1..8)
//     INIT_POLLS  number of ACMD41s needed to leave idle (>= 1)
//
//   Ports
//     clock   system clock; host SCLK must be at most clock/8
//     reset   asynchronous, active-high reset
//     bus     sd_spi_responder_if.slave (SPI pins + status outputs)
//
//   Build option
//     SD_RESP_CRC7_CHECK_EN  when defined, the CRC7 field of every frame is
//                            checked; a mismatch answers R1 = 0x08 | idle and
//                            the command is not executed. When undefined the
//                            CRC field is ignored and no CRC logic exists.
// ---------------------------------------------------------------------------
module sd_spi_responder #(
  parameter int RESP_DELAY = 1,
  parameter int INIT_POLLS = 2
) (
  input logic               clock,
  input logic               reset,
  sd_spi_responder_if.slave bus
);

  localparam int              PW         = (INIT_POLLS < 2) ? 1 : $clog2(INIT_POLLS + 1);
  localparam logic [PW-1:0]   POLL_MAX   = PW'(INIT_POLLS);
  localparam int              WAIT_RISES = 8 * RESP_DELAY;
  localparam logic [6:0]      WAIT_LAST  = 7'(WAIT_RISES - 1);
  // Synchronizer reset values for {sclk, cs_n, mosi}: clock low, deselected, idle-high data.
  localparam logic [2:0]      SYNC_RST   = 3'b011;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_RX,
    ST_WAIT,
    ST_TX
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // -------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizer per asynchronous pin
  // -------------------------------------------------------------------------
  logic [2:0] w_async_in;
  logic [2:0] w_sync;

  assign w_async_in = {bus.sd_sclk, bus.sd_cs_n, bus.sd_mosi};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic r_meta;
      logic r_q;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_meta <= SYNC_RST[gi];
          r_q    <= SYNC_RST[gi];
        end else begin
          r_meta <= w_async_in[gi];
          r_q    <= r_meta;
        end
      end
      assign w_sync[gi] = r_q;
    end
  endgenerate

  logic w_sclk;
  logic w_cs_high;
  logic w_mosi;
  logic r_sclk_prev;
  logic w_rise;
  logic w_fall;

  assign w_sclk    = w_sync[2];
  assign w_cs_high = w_sync[1];
  assign w_mosi    = w_sync[0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_sclk_prev <= 1'b0;
    else       r_sclk_prev <= w_sclk;
  end

  assign w_rise = w_sclk & ~r_sclk_prev;
  assign w_fall = ~w_sclk & r_sclk_prev;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // r_shift holds the first 47 frame bits (bit 47 ends up in r_shift[46]);
  // the 48th bit (end bit) is taken live from w_mosi on the final rise.
  logic [46:0]   r_shift;
  logic [5:0]    r_bit_cnt;
  logic [6:0]    r_wait_cnt;
  logic [2:0]    r_tx_cnt;
  logic [7:0]    r_r1_shift;
  logic          r_miso;
  logic          r_cmd_valid;
  logic [5:0]    r_cmd_index;
  logic [31:0]   r_cmd_arg;
  logic          r_idle;
  logic          r_app;
  logic [PW-1:0] r_polls;

  logic [5:0]    w_index;
  logic [31:0]   w_arg;
  logic          w_end_bit;
  logic          w_crc_err;
  logic          w_last_rx_bit;

  assign w_index       = r_shift[44:39];
  assign w_arg         = r_shift[38:7];
  assign w_end_bit     = w_mosi;
  assign w_last_rx_bit = (r_state == ST_RX) && w_rise && (r_bit_cnt == 6'd47);

`ifdef SD_RESP_CRC7_CHECK_EN
  // CRC7, polynomial x^7 + x^3 + 1, init 0, over frame bits 47:8 MSB first.
  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb  = crc[6] ^ data[i];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  assign w_crc_err = (crc7_calc(r_shift[46:7]) != r_shift[6:0]);
`else
  // Start/transmission bits are checked live and the CRC field is ignored,
  // so these shift-register bits have no reader in this build.
  logic w_unused_frame_bits;
  assign w_unused_frame_bits = ^{r_shift[46:45], r_shift[6:0]};
  assign w_crc_err           = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Command decode: R1 and next card state, evaluated on the completed frame
  // -------------------------------------------------------------------------
  logic [7:0]    w_r1;
  logic          w_accept;
  logic          w_idle_next;
  logic          w_app_next;
  logic [PW-1:0] w_polls_next;
  logic [PW-1:0] w_poll_inc;

  always_comb begin
    w_r1         = {5'd0, 1'b1, 1'b0, r_idle};   // illegal command
    w_accept     = 1'b0;
    w_idle_next  = r_idle;
    w_app_next   = r_app;
    w_polls_next = r_polls;
    // Saturating increment so long ACMD41 loops cannot wrap the counter.
    w_poll_inc   = (r_polls == POLL_MAX) ? r_polls : PW'(r_polls + 1'b1);

    if (!w_end_bit) begin
      // Framing error: illegal-command R1, nothing executed.
      w_r1 = {5'd0, 1'b1, 1'b0, r_idle};
    end else if (w_crc_err) begin
      w_r1 = {4'd0, 1'b1, 2'd0, r_idle};
    end else begin
      w_accept   = 1'b1;
      w_app_next = 1'b0;
      case (w_index)
        6'd0: begin
          w_idle_next  = 1'b1;
          w_polls_next = '0;
          w_r1         = 8'h01;
        end
        6'd1: begin
          w_idle_next = 1'b0;
          w_r1        = 8'h00;
        end
        6'd16: begin
          w_r1 = {7'd0, r_idle};
        end
        6'd55: begin
          w_app_next = 1'b1;
          w_r1       = {7'd0, r_idle};
        end
        6'd41: begin
          if (r_app) begin
            w_polls_next = w_poll_inc;
            if (w_poll_inc == POLL_MAX) w_idle_next = 1'b0;
            w_r1 = {7'd0, w_idle_next};
          end else begin
            w_r1 = {5'd0, 1'b1, 1'b0, r_idle};
          end
        end
        default: begin
          w_r1 = {5'd0, 1'b1, 1'b0, r_idle};
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_HUNT;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_cs_high) begin
      w_state_next = ST_HUNT;
    end else begin
      case (r_state)
        ST_HUNT: if (w_rise && !w_mosi) w_state_next = ST_RX;
        ST_RX: begin
          if (w_rise) begin
            // Second bit is the transmission bit; 0 means not a host frame.
            if (r_bit_cnt == 6'd1 && !w_mosi) w_state_next = ST_HUNT;
            else if (r_bit_cnt == 6'd47)      w_state_next = ST_WAIT;
          end
        end
        ST_WAIT: if (w_rise && r_wait_cnt == WAIT_LAST) w_state_next = ST_TX;
        ST_TX:   if (w_rise && r_tx_cnt == 3'd7)        w_state_next = ST_HUNT;
        default: w_state_next = ST_HUNT;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath sequencing
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_tx_cnt    <= '0;
      r_r1_shift  <= 8'hFF;
      r_miso      <= 1'b1;
      r_cmd_valid <= 1'b0;
      r_cmd_index <= '0;
      r_cmd_arg   <= '0;
      r_idle      <= 1'b1;
      r_app       <= 1'b0;
      r_polls     <= '0;
    end else begin
      r_cmd_valid <= 1'b0;
      if (w_cs_high) begin
        r_miso <= 1'b1;
      end else begin
        case (r_state)
          ST_HUNT: begin
            if (w_fall) r_miso <= 1'b1;
            if (w_rise && !w_mosi) begin
              r_shift   <= '0;
              r_bit_cnt <= 6'd1;
            end
          end
          ST_RX: begin
            if (w_fall) r_miso <= 1'b1;
            if (w_rise) begin
              r_shift   <= {r_shift[45:0], w_mosi};
              r_bit_cnt <= r_bit_cnt + 6'd1;
            end
            if (w_last_rx_bit) begin
              r_cmd_index <= w_index;
              r_cmd_arg   <= w_arg;
              r_cmd_valid <= w_accept;
              r_idle      <= w_idle_next;
              r_app       <= w_app_next;
              r_polls     <= w_polls_next;
              r_r1_shift  <= w_r1;
              r_wait_cnt  <= '0;
            end
          end
          ST_WAIT: begin
            if (w_fall) r_miso <= 1'b1;
            if (w_rise) begin
              r_wait_cnt <= r_wait_cnt + 7'd1;
              if (r_wait_cnt == WAIT_LAST) r_tx_cnt <= '0;
            end
          end
          ST_TX: begin
            // The first fall in TX is the one after the last WAIT rise.
            if (w_fall) begin
              r_miso     <= r_r1_shift[7];
              r_r1_shift <= {r_r1_shift[6:0], 1'b1};
            end
            if (w_rise) r_tx_cnt <= r_tx_cnt + 3'd1;
          end
          default: r_miso <= 1'b1;
        endcase
      end
    end
  end

  assign bus.sd_miso   = r_miso;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_index = r_cmd_index;
  assign bus.cmd_arg   = r_cmd_arg;
  assign bus.card_idle = r_idle;
  assign bus.busy      = (r_state != ST_HUNT);

endmodule

// File: tb/tb_sd_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_sd_spi_responder
//   Directed bench for sd_spi_responder: acts as the SPI host, sends
//   hand-built command frames and compares R1 bytes and status outputs
//   against hand-computed values.
// ---------------------------------------------------------------------------
module tb_sd_spi_responder;
  localparam int RESP_DELAY = 2;
  localparam int INIT_POLLS = 2;
  localparam int HALF       = 8;   // SCLK half period in system clocks

  logic clock = 1'b0;
  logic reset = 1'b1;

  sd_spi_responder_if sd_if ();

  sd_spi_responder #(
    .RESP_DELAY (RESP_DELAY),
    .INIT_POLLS (INIT_POLLS)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sd_if)
  );

  always #5 clock = ~clock;

  int n_checks  = 0;
  int n_errors  = 0;
  int valid_cnt = 0;

  always @(negedge clock) begin
    if (sd_if.cmd_valid === 1'b1) valid_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sd_if.sd_mosi = tx[7-i];
      repeat (HALF) @(negedge clock);
      sd_if.sd_sclk = 1'b1;
      rx = {rx[6:0], sd_if.sd_miso};
      repeat (HALF) @(negedge clock);
      sd_if.sd_sclk = 1'b0;
    end
    sd_if.sd_mosi = 1'b1;
  endtask

  task automatic send_frame(input logic [47:0] frame);
    logic [7:0] rx;
    for (int b = 0; b < 6; b++) spi_xfer(frame[47-8*b -: 8], 8, rx);
  endtask

  // Full command transaction: frame, NCR bytes, R1, then deselect.
  task automatic run_cmd(input string tag, input logic [47:0] frame,
                         input logic [7:0] exp_r1, input int exp_valid);
    logic [7:0] rx;
    int         v0;
    v0 = valid_cnt;
    sd_if.sd_cs_n = 1'b0;
    repeat (HALF) @(negedge clock);
    send_frame(frame);
    repeat (4) @(negedge clock);
    check_eq({tag, "_busy_wait"}, 32'(sd_if.busy), 32'd1);
    for (int d = 0; d < RESP_DELAY; d++) begin
      spi_xfer(8'hFF, 8, rx);
      check_eq({tag, "_ncr"}, 32'(rx), 32'hFF);
    end
    spi_xfer(8'hFF, 8, rx);
    check_eq({tag, "_r1"}, 32'(rx), 32'(exp_r1));
    repeat (4) @(negedge clock);
    check_eq({tag, "_busy_done"}, 32'(sd_if.busy), 32'd0);
    check_eq({tag, "_miso_idle"}, 32'(sd_if.sd_miso), 32'd1);
    check_eq({tag, "_valid"}, 32'(valid_cnt - v0), 32'(exp_valid));
    $display("cmd %-10s frame=%012h r1=%02h idle=%0b", tag, frame, rx, sd_if.card_idle);
    sd_if.sd_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clock);
  endtask

  localparam logic [47:0] CMD0     = 48'h40_0000_0000_95;
  localparam logic [47:0] CMD0_BAD = 48'h40_0000_0000_01;
  localparam logic [47:0] CMD0_EB0 = 48'h40_0000_0000_94;
  localparam logic [47:0] CMD1     = 48'h41_0000_0000_F9;
  localparam logic [47:0] CMD8     = 48'h48_0000_01AA_87;
  localparam logic [47:0] CMD55    = 48'h77_0000_0000_65;
  localparam logic [47:0] ACMD41   = 48'h69_4000_0000_77;
`ifdef SD_RESP_CRC7_CHECK_EN
  localparam logic [47:0] CMD17    = 48'h51_0000_0200_79;
`else
  localparam logic [47:0] CMD17    = 48'h51_0000_0200_55;
`endif

  initial begin
    logic [7:0] rx;
    int         v0;

    sd_if.sd_sclk = 1'b0;
    sd_if.sd_cs_n = 1'b1;
    sd_if.sd_mosi = 1'b1;

    repeat (5) @(negedge clock);
    check_eq("rst_miso",  32'(sd_if.sd_miso),   32'd1);
    check_eq("rst_valid", 32'(sd_if.cmd_valid), 32'd0);
    check_eq("rst_index", 32'(sd_if.cmd_index), 32'd0);
    check_eq("rst_arg",   sd_if.cmd_arg,        32'd0);
    check_eq("rst_idle",  32'(sd_if.card_idle), 32'd1);
    check_eq("rst_busy",  32'(sd_if.busy),      32'd0);
    $display("reset released");
    reset = 1'b0;
    repeat (5) @(negedge clock);

    run_cmd("cmd0", CMD0, 8'h01, 1);
    check_eq("cmd0_index", 32'(sd_if.cmd_index), 32'd0);
    check_eq("cmd0_arg",   sd_if.cmd_arg,        32'd0);
    check_eq("cmd0_idle",  32'(sd_if.card_idle), 32'd1);

    run_cmd("cmd8", CMD8, 8'h05, 1);
    check_eq("cmd8_index", 32'(sd_if.cmd_index), 32'd8);
    check_eq("cmd8_arg",   sd_if.cmd_arg,        32'h0000_01AA);

    run_cmd("cmd55_a", CMD55, 8'h01, 1);
    run_cmd("acmd41_a", ACMD41, 8'h01, 1);
    check_eq("acmd41_a_idle", 32'(sd_if.card_idle), 32'd1);
    run_cmd("cmd55_b", CMD55, 8'h01, 1);
    run_cmd("acmd41_b", ACMD41, 8'h00, 1);
    check_eq("acmd41_b_idle",  32'(sd_if.card_idle), 32'd0);
    check_eq("acmd41_b_index", 32'(sd_if.cmd_index), 32'd41);
    check_eq("acmd41_b_arg",   sd_if.cmd_arg,        32'h4000_0000);

    run_cmd("cmd17", CMD17, 8'h04, 1);
    check_eq("cmd17_index", 32'(sd_if.cmd_index), 32'd17);
    check_eq("cmd17_arg",   sd_if.cmd_arg,        32'h0000_0200);

    // Abort a CMD0 after 20 bits: nothing may execute.
    v0 = valid_cnt;
    sd_if.sd_cs_n = 1'b0;
    repeat (HALF) @(negedge clock);
    spi_xfer(8'h40, 8, rx);
    spi_xfer(8'h00, 8, rx);
    spi_xfer(8'h00, 4, rx);
    sd_if.sd_cs_n = 1'b1;
    repeat (4) @(negedge clock);
    check_eq("abort_valid", 32'(valid_cnt - v0),  32'd0);
    check_eq("abort_miso",  32'(sd_if.sd_miso),   32'd1);
    check_eq("abort_busy",  32'(sd_if.busy),      32'd0);
    check_eq("abort_idle",  32'(sd_if.card_idle), 32'd0);
    $display("abort after 20 bits");
    repeat (2 * HALF) @(negedge clock);
    run_cmd("cmd0_post", CMD0, 8'h01, 1);
    check_eq("cmd0_post_idle", 32'(sd_if.card_idle), 32'd1);

`ifdef SD_RESP_CRC7_CHECK_EN
    run_cmd("cmd0_crc", CMD0_BAD, 8'h09, 0);
`else
    run_cmd("cmd0_crc", CMD0_BAD, 8'h01, 1);
`endif

    run_cmd("cmd0_eb0", CMD0_EB0, 8'h05, 0);

    run_cmd("cmd1", CMD1, 8'h00, 1);
    check_eq("cmd1_idle", 32'(sd_if.card_idle), 32'd0);

    // Reset while TX is driving R1 bit 7 of CMD8 (R1 = 0x04, bit 7 = 0).
    sd_if.sd_cs_n = 1'b0;
    repeat (HALF) @(negedge clock);
    send_frame(CMD8);
    for (int d = 0; d < RESP_DELAY; d++) spi_xfer(8'hFF, 8, rx);
    repeat (4) @(negedge clock);
    check_eq("tx_bit7_miso", 32'(sd_if.sd_miso), 32'd0);
    check_eq("tx_busy",      32'(sd_if.busy),    32'd1);
    #3;
    reset = 1'b1;
    #1;
    check_eq("midtx_rst_miso",  32'(sd_if.sd_miso),   32'd1);
    check_eq("midtx_rst_busy",  32'(sd_if.busy),      32'd0);
    check_eq("midtx_rst_idle",  32'(sd_if.card_idle), 32'd1);
    check_eq("midtx_rst_index", 32'(sd_if.cmd_index), 32'd0);
    check_eq("midtx_rst_arg",   sd_if.cmd_arg,        32'd0);
    $display("reset asserted mid-TX");
    sd_if.sd_cs_n = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    run_cmd("cmd55_rec", CMD55, 8'h01, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
